// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: default widths, ALU op
// class encodings and the packed control bundle carried between stages.
package pipeline_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int ALU_OP_W = 2;

    // ALU op class produced by the main decoder
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD_SUB_LW_SW = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_OP_BEQ           = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_OP_R_TYPE        = 2'b10;

    // Decoded control bits travelling with an instruction
    typedef struct packed {
        logic                reg_dst;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                mem_to_reg;
        logic                branch;
    } ctrl_t;

    // A bubble carries no side effects at all
    localparam ctrl_t CTRL_BUBBLE = '0;

    // Drop the control bits of an invalid instruction so it cannot write state
    function automatic ctrl_t mask_ctrl(input ctrl_t ctrl, input logic valid);
        return valid ? ctrl : CTRL_BUBBLE;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags when the load now in EX writes a
// register that the instruction in ID reads. Purely combinational so a
// forwarding unit can reuse it.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    output logic             load_use_stall
);

    logic [REG_W-1:0] src_reg [2];
    logic [1:0]       src_hit;

    assign src_reg[0] = id_rs;
    assign src_reg[1] = id_rt;

    // One comparator per ID source specifier
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_hit[gi] = (ex_rt == src_reg[gi]);
        end
    endgenerate

    // $zero is never a real destination, so it can never cause a stall
    assign load_use_stall = id_valid & ex_valid & ex_mem_read
                          & (ex_rt != '0) & (|src_hit);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, external hold
// and flush. Per edge: flush > hold > load-use bubble > normal capture.
// Optional macro ID_EX_PC_TRACE_EN adds an id_pc -> ex_pc trace path.
module id_ex_pipe_reg #(
    parameter int DATA_W   = pipeline_pkg::DATA_W,
    parameter int REG_W    = pipeline_pkg::REG_W,
    parameter int ALU_OP_W = pipeline_pkg::ALU_OP_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [DATA_W-1:0]   id_read_data_1,
    input  logic [DATA_W-1:0]   id_read_data_2,
    input  logic [DATA_W-1:0]   id_sign_ext_imm,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                id_reg_dst,
    input  logic                id_alu_src,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_reg_write,
    input  logic                id_mem_to_reg,
    input  logic                id_branch,
    input  logic [ALU_OP_W-1:0] id_alu_op,
`ifdef ID_EX_PC_TRACE_EN
    input  logic [DATA_W-1:0]   id_pc,
    output logic [DATA_W-1:0]   ex_pc,
`endif
    input  logic                flush,
    input  logic                hold,
    output logic                ex_valid,
    output logic [DATA_W-1:0]   ex_read_data_1,
    output logic [DATA_W-1:0]   ex_read_data_2,
    output logic [DATA_W-1:0]   ex_sign_ext_imm,
    output logic [REG_W-1:0]    ex_rs,
    output logic [REG_W-1:0]    ex_rt,
    output logic [REG_W-1:0]    ex_rd,
    output logic                ex_reg_dst,
    output logic                ex_alu_src,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_reg_write,
    output logic                ex_mem_to_reg,
    output logic                ex_branch,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                load_use_stall
);

    import pipeline_pkg::*;

    logic              valid_reg;
    logic [DATA_W-1:0] read_data_1_reg;
    logic [DATA_W-1:0] read_data_2_reg;
    logic [DATA_W-1:0] sign_ext_imm_reg;
    logic [REG_W-1:0]  rs_reg;
    logic [REG_W-1:0]  rt_reg;
    logic [REG_W-1:0]  rd_reg;
    ctrl_t             ctrl_reg;
    ctrl_t             id_ctrl;
    logic              bubble;

    assign id_ctrl = '{
        reg_dst:    id_reg_dst,
        alu_src:    id_alu_src,
        alu_op:     id_alu_op,
        mem_read:   id_mem_read,
        mem_write:  id_mem_write,
        reg_write:  id_reg_write,
        mem_to_reg: id_mem_to_reg,
        branch:     id_branch
    };

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .ex_valid       (valid_reg),
        .ex_mem_read    (ctrl_reg.mem_read),
        .ex_rt          (rt_reg),
        .load_use_stall (load_use_stall)
    );

    // Flush always squashes; a load-use bubble only when the pipe is not frozen
    assign bubble = flush | (~hold & load_use_stall);

    // Stage register: clear on reset or bubble, keep on hold, otherwise capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg        <= 1'b0;
            read_data_1_reg  <= '0;
            read_data_2_reg  <= '0;
            sign_ext_imm_reg <= '0;
            rs_reg           <= '0;
            rt_reg           <= '0;
            rd_reg           <= '0;
            ctrl_reg         <= CTRL_BUBBLE;
        end else if (bubble) begin
            valid_reg        <= 1'b0;
            read_data_1_reg  <= '0;
            read_data_2_reg  <= '0;
            sign_ext_imm_reg <= '0;
            rs_reg           <= '0;
            rt_reg           <= '0;
            rd_reg           <= '0;
            ctrl_reg         <= CTRL_BUBBLE;
        end else if (!hold) begin
            valid_reg        <= id_valid;
            read_data_1_reg  <= id_read_data_1;
            read_data_2_reg  <= id_read_data_2;
            sign_ext_imm_reg <= id_sign_ext_imm;
            rs_reg           <= id_rs;
            rt_reg           <= id_rt;
            rd_reg           <= id_rd;
            ctrl_reg         <= mask_ctrl(id_ctrl, id_valid);
        end
    end

`ifdef ID_EX_PC_TRACE_EN
    logic [DATA_W-1:0] pc_reg;

    // Trace PC follows exactly the same reset/bubble/hold rules as the stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg <= '0;
        end else if (bubble) begin
            pc_reg <= '0;
        end else if (!hold) begin
            pc_reg <= id_pc;
        end
    end

    assign ex_pc = pc_reg;
`endif

    assign ex_valid        = valid_reg;
    assign ex_read_data_1  = read_data_1_reg;
    assign ex_read_data_2  = read_data_2_reg;
    assign ex_sign_ext_imm = sign_ext_imm_reg;
    assign ex_rs           = rs_reg;
    assign ex_rt           = rt_reg;
    assign ex_rd           = rd_reg;
    assign ex_reg_dst      = ctrl_reg.reg_dst;
    assign ex_alu_src      = ctrl_reg.alu_src;
    assign ex_alu_op       = ctrl_reg.alu_op;
    assign ex_mem_read     = ctrl_reg.mem_read;
    assign ex_mem_write    = ctrl_reg.mem_write;
    assign ex_reg_write    = ctrl_reg.reg_write;
    assign ex_mem_to_reg   = ctrl_reg.mem_to_reg;
    assign ex_branch       = ctrl_reg.branch;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_read_data_1, id_read_data_2, id_sign_ext_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_reg_dst, id_alu_src, id_mem_read, id_mem_write;
    logic        id_reg_write, id_mem_to_reg, id_branch;
    logic [1:0]  id_alu_op;
    logic        flush, hold;
    logic        ex_valid;
    logic [31:0] ex_read_data_1, ex_read_data_2, ex_sign_ext_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write;
    logic        ex_reg_write, ex_mem_to_reg, ex_branch;
    logic [1:0]  ex_alu_op;
    logic        load_use_stall;
`ifdef ID_EX_PC_TRACE_EN
    logic [31:0] id_pc, ex_pc, m_pc;
`endif

    // Behavioural model of what EX must present
    logic        m_valid;
    logic [31:0] m_d1, m_d2, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic        m_reg_dst, m_alu_src, m_mem_read, m_mem_write;
    logic        m_reg_write, m_mem_to_reg, m_branch;
    logic [1:0]  m_alu_op;

    int vectors = 0;
    int errors  = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_read_data_1  (id_read_data_1),
        .id_read_data_2  (id_read_data_2),
        .id_sign_ext_imm (id_sign_ext_imm),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_reg_dst      (id_reg_dst),
        .id_alu_src      (id_alu_src),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_reg_write    (id_reg_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .id_branch       (id_branch),
        .id_alu_op       (id_alu_op),
`ifdef ID_EX_PC_TRACE_EN
        .id_pc           (id_pc),
        .ex_pc           (ex_pc),
`endif
        .flush           (flush),
        .hold            (hold),
        .ex_valid        (ex_valid),
        .ex_read_data_1  (ex_read_data_1),
        .ex_read_data_2  (ex_read_data_2),
        .ex_sign_ext_imm (ex_sign_ext_imm),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_rd           (ex_rd),
        .ex_reg_dst      (ex_reg_dst),
        .ex_alu_src      (ex_alu_src),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_branch       (ex_branch),
        .ex_alu_op       (ex_alu_op),
        .load_use_stall  (load_use_stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Hazard rule: a valid load in EX whose non-zero rt is read by a valid ID op
    function automatic logic exp_stall();
        return id_valid && m_valid && m_mem_read && (m_rt != 5'd0)
               && ((m_rt == id_rs) || (m_rt == id_rt));
    endfunction

    task automatic model_clear();
        m_valid = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_rd = 0;
        m_reg_dst = 0; m_alu_src = 0; m_mem_read = 0; m_mem_write = 0;
        m_reg_write = 0; m_mem_to_reg = 0; m_branch = 0; m_alu_op = 0;
`ifdef ID_EX_PC_TRACE_EN
        m_pc = 0;
`endif
    endtask

    // Apply one rising edge to the model using the inputs present at that edge
    task automatic model_edge();
        logic v;
        if (reset) model_clear();
        else if (flush) model_clear();
        else if (hold) begin
            // frozen
        end else if (exp_stall()) model_clear();
        else begin
            v = id_valid;
            m_valid = v;
            m_d1 = id_read_data_1; m_d2 = id_read_data_2; m_imm = id_sign_ext_imm;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_reg_dst    = v & id_reg_dst;
            m_alu_src    = v & id_alu_src;
            m_alu_op     = v ? id_alu_op : 2'b00;
            m_mem_read   = v & id_mem_read;
            m_mem_write  = v & id_mem_write;
            m_reg_write  = v & id_reg_write;
            m_mem_to_reg = v & id_mem_to_reg;
            m_branch     = v & id_branch;
`ifdef ID_EX_PC_TRACE_EN
            m_pc = id_pc;
`endif
        end
    endtask

    // Compare process: every cycle, all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ex_valid", ex_valid, m_valid);
            chk("ex_read_data_1", ex_read_data_1, m_d1);
            chk("ex_read_data_2", ex_read_data_2, m_d2);
            chk("ex_sign_ext_imm", ex_sign_ext_imm, m_imm);
            chk("ex_rs", ex_rs, m_rs);
            chk("ex_rt", ex_rt, m_rt);
            chk("ex_rd", ex_rd, m_rd);
            chk("ex_ctrl", {ex_reg_dst, ex_alu_src, ex_alu_op, ex_mem_read, ex_mem_write,
                            ex_reg_write, ex_mem_to_reg, ex_branch},
                           {m_reg_dst, m_alu_src, m_alu_op, m_mem_read, m_mem_write,
                            m_reg_write, m_mem_to_reg, m_branch});
            chk("load_use_stall", load_use_stall, exp_stall());
`ifdef ID_EX_PC_TRACE_EN
            chk("ex_pc", ex_pc, m_pc);
`endif
            if (!ex_valid)
                chk("bubble_ctrl", {ex_reg_write, ex_mem_write, ex_mem_read, ex_branch}, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] d1,
                             input logic mr, input logic rw, input logic rdst);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_read_data_1 = d1; id_read_data_2 = d1 ^ 32'hFFFF_0000; id_sign_ext_imm = {27'd0, rd};
        id_mem_read = mr; id_reg_write = rw; id_reg_dst = rdst;
        id_alu_src = mr; id_mem_to_reg = mr; id_mem_write = 0; id_branch = 0;
        id_alu_op = rdst ? 2'b10 : 2'b00;
`ifdef ID_EX_PC_TRACE_EN
        id_pc = d1 + 32'h400;
`endif
    endtask

    task automatic randomize_inputs();
        id_valid        = ($urandom_range(0, 9) != 0);
        id_read_data_1  = $urandom;
        id_read_data_2  = $urandom;
        id_sign_ext_imm = $urandom;
        id_rs           = 5'($urandom_range(0, 3));
        id_rt           = 5'($urandom_range(0, 3));
        id_rd           = 5'($urandom);
        id_reg_dst      = 1'($urandom);
        id_alu_src      = 1'($urandom);
        id_mem_read     = ($urandom_range(0, 4) < 2);
        id_mem_write    = 1'($urandom);
        id_reg_write    = 1'($urandom);
        id_mem_to_reg   = 1'($urandom);
        id_branch       = 1'($urandom);
        id_alu_op       = 2'($urandom_range(0, 2));
        flush           = ($urandom_range(0, 9) == 0);
        hold            = ($urandom_range(0, 6) == 0);
`ifdef ID_EX_PC_TRACE_EN
        id_pc           = $urandom;
`endif
    endtask

    initial begin
        reset = 1; flush = 0; hold = 0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk_en = 1;
        #1;
        chk("reset_ex_valid", ex_valid, 0);
        chk("reset_stall", load_use_stall, 0);

        // Normal capture
        set_instr(1, 5'd1, 5'd5, 5'd9, 32'h1234, 0, 1, 1);
        step(); #1;
        chk("cap_ex_rt", ex_rt, 5);
        chk("cap_ex_rd", ex_rd, 9);
        chk("cap_ex_reg_dst", ex_reg_dst, 1);
        chk("cap_ex_read_data_1", ex_read_data_1, 32'h1234);
        chk("cap_ex_valid", ex_valid, 1);

        // Load-use: lw rt=8 then add rs=8
        set_instr(1, 5'd2, 5'd8, 5'd0, 32'h40, 1, 1, 0);
        step();
        set_instr(1, 5'd8, 5'd3, 5'd10, 32'h77, 0, 1, 1);
        #1 chk("lu_stall_high", load_use_stall, 1);
        step(); #1;
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_reg_write", ex_reg_write, 0);
        chk("lu_stall_drop", load_use_stall, 0);
        step(); #1;
        chk("lu_add_rd", ex_rd, 10);
        chk("lu_add_rs", ex_rs, 8);
        chk("lu_add_valid", ex_valid, 1);

        // lw to $zero never stalls
        set_instr(1, 5'd4, 5'd0, 5'd0, 32'h50, 1, 1, 0);
        step();
        set_instr(1, 5'd0, 5'd0, 5'd12, 32'h60, 0, 1, 1);
        #1 chk("zero_stall", load_use_stall, 0);
        step(); #1;
        chk("zero_cap_valid", ex_valid, 1);
        chk("zero_cap_rd", ex_rd, 12);

        // Flush beats hold
        set_instr(1, 5'd6, 5'd7, 5'd13, 32'h99, 0, 1, 1);
        flush = 1; hold = 1;
        step(); #1;
        chk("fh_valid", ex_valid, 0);
        chk("fh_ctrl", {ex_reg_dst, ex_reg_write, ex_alu_op}, 0);
        flush = 0; hold = 0;

        // Hold for 3 cycles while ID changes
        set_instr(1, 5'd1, 5'd2, 5'd17, 32'hAAAA, 0, 1, 1);
        step();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(1, 5'd3, 5'd4, 5'(20 + i), 32'h100 + 32'(i), 0, 1, 0);
            step(); #1;
            chk("hold_rd", ex_rd, 17);
            chk("hold_d1", ex_read_data_1, 32'hAAAA);
        end
        hold = 0;
        set_instr(1, 5'd3, 5'd4, 5'd25, 32'hBBBB, 0, 1, 1);
        step(); #1;
        chk("release_rd", ex_rd, 25);
        chk("release_d1", ex_read_data_1, 32'hBBBB);

        // Invalid ID instruction: controls forced off, data still captured
        set_instr(0, 5'd1, 5'd2, 5'd14, 32'hCCCC, 1, 1, 1);
        step(); #1;
        chk("inv_reg_write", ex_reg_write, 0);
        chk("inv_mem_read", ex_mem_read, 0);
        chk("inv_rd", ex_rd, 14);

        // Async reset mid-cycle clears immediately
        set_instr(1, 5'd1, 5'd2, 5'd15, 32'hDDDD, 0, 1, 1);
        step();
        #1 chk("pre_rst_reg_write", ex_reg_write, 1);
        reset = 1;
        #1;
        model_clear();
        chk("rst_reg_write", ex_reg_write, 0);
        chk("rst_valid", ex_valid, 0);
        chk("rst_rd", ex_rd, 0);
        reset = 0;
        set_instr(1, 5'd1, 5'd2, 5'd16, 32'hEEEE, 0, 1, 1);
        step(); #1;
        chk("post_rst_valid", ex_valid, 1);
        chk("post_rst_rd", ex_rd, 16);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            step();
            if ($urandom_range(0, 199) == 0) begin
                reset = 1;
                #1;
                model_clear();
                chk("rand_rst_valid", ex_valid, 0);
                reset = 0;
            end
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Decode/execute pipeline register of the 5-stage MIPS core. It captures decoded operands, register specifiers and control bits from ID and presents them to EX. That includes rt/rd and RegDst, which feed the EX destination-register mux. It also contains load-use hazard detection, and supports hold (external stall) and flush (bubble insertion).

Parameters:
DATA_W, 32, operand/immediate width
REG_W, 5, register specifier width
ALU_OP_W, 2, ALU op control width

Ports:
clk  in  1  core clock, rising-edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_read_data_1  in  DATA_W  rs operand
id_read_data_2  in  DATA_W  rt operand
id_sign_ext_imm  in  DATA_W  sign-extended immediate
id_rs  in  REG_W  rs specifier
id_rt  in  REG_W  rt specifier (L-type destination)
id_rd  in  REG_W  rd specifier (R-type destination)
id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch  in  1 each  decoded control
id_alu_op  in  ALU_OP_W  ALU op class
flush  in  1  squash ID instruction (taken branch/jump)
hold  in  1  freeze whole pipe (memory wait)
ex_valid  out  1  EX instruction valid
ex_read_data_1, ex_read_data_2, ex_sign_ext_imm  out  DATA_W  registered operands
ex_rs, ex_rt, ex_rd  out  REG_W  registered specifiers
ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch  out  1 each  registered control
ex_alu_op  out  ALU_OP_W  registered ALU op
load_use_stall  out  1  combinational; upstream PC and IF/ID must hold

Behaviour:
- Reset (async, active-high): all registered outputs 0; load_use_stall therefore 0.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)). Combinational from current register state and ID inputs.
- Priority per rising edge: flush > hold > load_use_stall > normal capture.
- flush: insert bubble. ex_valid=0; every control output 0; data and specifiers 0. Applies even if hold is also asserted.
- hold (no flush): all registers keep their value. load_use_stall is still evaluated combinationally, but it does not change state.
- load_use_stall (no flush/hold): insert bubble as for flush. ID instruction is not captured; it is re-presented next cycle by the held upstream stages. Stall lasts exactly 1 cycle, because after the bubble ex_mem_read=0.
- Normal: capture all id_* into ex_*; ex_valid=id_valid. If id_valid=0, control outputs are forced to 0 regardless of id_* control.
- Bubble invariants: ex_valid=0 implies ex_reg_write=ex_mem_write=ex_mem_read=ex_branch=0.
- rt=0 destination never triggers a stall ($zero).
- Reset mid-operation clears any pending stall/bubble immediately; first post-reset edge performs a normal capture.

Optional Feature:
Macro ID_EX_PC_TRACE_EN.
- Defined: adds input id_pc[DATA_W-1:0] and output ex_pc[DATA_W-1:0], captured with the same hold/flush/bubble rules (0 on bubble and reset). Used by the trace/debug bench.
- Undefined: ports absent; no PC storage.

Decomposition:
- Shared package (pipeline_pkg): REG_W, ALU_OP_W, DATA_W defaults; ALU op encodings (ADD_SUB_LW_SW=2'b00, BEQ=2'b01, R_TYPE=2'b10); a packed control-bundle struct (reg_dst, alu_src, alu_op, mem_read, mem_write, reg_write, mem_to_reg, branch) plus a CTRL_BUBBLE all-zeros constant.
- One sub-module: load_use_detect (pure combinational comparator producing load_use_stall), reusable by a future forwarding unit.

Test Plan:
- Reset: assert reset mid-cycle with ex_reg_write=1 -> all ex_* outputs 0 immediately, before any clock edge.
- Normal capture: id_rt=5, id_rd=9, id_reg_dst=1, id_reg_write=1, data 0x1234 -> next edge ex_rt=5, ex_rd=9, ex_reg_dst=1, ex_read_data_1=0x1234, ex_valid=1.
- Load-use: cycle N lw with rt=8 enters EX; ID add rs=8 -> load_use_stall=1; next edge EX holds bubble (ex_reg_write=0, ex_valid=0); stall drops; following edge captures the add.
- $zero: lw rt=0 in EX, ID rs=0 -> load_use_stall=0, normal capture.
- Flush+hold together: flush=1, hold=1, valid instruction in ID -> next edge ex_valid=0 and all control 0.
- Hold: hold=1 for 3 cycles while ID inputs change -> ex_* unchanged; on release, capture the ID values present on the release edge.
